dot_product_sequencer: RTL and testbench
========================================

Name: dot_product_sequencer

Overview:
- Job-level controller for the dot-product datapath.
- Takes a job of N result rows and, for each row, starts the dot-product core, captures its result, hands it to the output memory writer with the result_valid / processing_done handshake, and waits for writer_done.
- Sits between the host/control registers, the dot-product core and the output memory wrapper.
- Tracks row index and written count, and reports job completion.

Parameters:
- DATA_WIDTH, 8, element width of input vectors.
- VECTOR_WIDTH, 4, elements per dot product.
- ADDR_WIDTH, 4, vector/result address width.
- RESULT_WIDTH, 2*DATA_WIDTH+$clog2(VECTOR_WIDTH) (=18), dot-product result width.
- TIMEOUT_CYCLES, 64, watchdog limit per wait state (used only with the optional feature).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  job start pulse; sampled only in IDLE.
- num_results  in  ADDR_WIDTH+1  rows in job, latched at start.
- base_addr  in  ADDR_WIDTH  first vector/result index, latched at start.
- abort  in  1  cancel current job.
- dp_start  out  1  one-cycle start pulse to dot-product core.
- dp_vec_index  out  ADDR_WIDTH  row index for the core.
- dp_result  in  RESULT_WIDTH  core result.
- dp_valid  in  1  core result valid, one cycle.
- dot_product_result  out  RESULT_WIDTH  registered result to writer.
- result_valid  out  1  result strobe to writer.
- processing_done  out  1  commit strobe to writer.
- writer_busy  in  1  writer accepted result.
- writer_done  in  1  writer finished store.
- busy  out  1  job in progress.
- done  out  1  one-cycle job-complete pulse.
- rows_written  out  ADDR_WIDTH+1  rows committed in current/last job.
- error  out  1  sticky watchdog error; cleared by next accepted start.

Behaviour:
- Reset:
  - All outputs are 0, the FSM is in IDLE and all latched registers are 0.
  - Reset asserted mid-job aborts immediately with no done pulse.
- FSM states: IDLE, ISSUE, WAIT_DP, PUSH, WAIT_BUSY, COMMIT, WAIT_DONE, NEXT, FINISH.
- IDLE:
  - On start=1, latch num_results and base_addr, clear rows_written and error.
  - If num_results!=0, go to ISSUE and assert busy from the next cycle.
  - If num_results==0, go to FINISH with no datapath or writer activity.
- ISSUE:
  - dp_start=1 for exactly one cycle.
  - dp_vec_index = base_addr + rows_written, truncated to ADDR_WIDTH (wraps modulo 2^ADDR_WIDTH).
  - Go to WAIT_DP.
- WAIT_DP:
  - Hold until dp_valid=1, then register dp_result into dot_product_result and go to PUSH.
  - dp_valid in any other state is ignored.
- PUSH: result_valid=1 for one cycle, then go to WAIT_BUSY.
- WAIT_BUSY: hold until writer_busy=1, then go to COMMIT.
- COMMIT: processing_done=1 for one cycle, then go to WAIT_DONE.
- WAIT_DONE: hold until writer_done=1, then go to NEXT.
- NEXT:
  - rows_written increments.
  - If the new count equals num_results, go to FINISH; otherwise go to ISSUE.
- FINISH:
  - done=1 for one cycle and busy=0 from the same cycle.
  - Go to IDLE.
  - rows_written holds its value until the next start.
- Strobe behaviour: result_valid, processing_done and dp_start are strictly single-cycle, never overlap, and are 0 in IDLE.
- Result hold: dot_product_result is stable from PUSH through WAIT_DONE.
- Minimum per-row latency with zero-wait core and writer: 7 cycles from ISSUE to the next ISSUE.
- start while busy: ignored, and latched values are unaffected.
- abort=1 in any non-IDLE state:
  - Go to IDLE next cycle with all strobes cleared and busy=0.
  - No done pulse; rows_written holds the partial count.
  - abort has priority over every other transition in the same cycle.
  - abort in IDLE has no effect.
- Simultaneous start and abort in IDLE: start wins.

Optional Feature:
- Macro SEQ_TIMEOUT_EN.
- Defined:
  - A counter runs in WAIT_DP, WAIT_BUSY and WAIT_DONE and resets on every state entry.
  - Reaching TIMEOUT_CYCLES without the awaited input sets error=1 and returns the FSM to IDLE, with busy=0 and no done pulse.
- Not defined: waits are unbounded, error is tied to 0 and no counter logic is built.

Test Plan:
- Single row:
  - Stimulus: start, num_results=1, base_addr=0; core returns dp_valid with dp_result=42 after 3 cycles; writer asserts writer_busy 1 cycle after result_valid and writer_done 2 cycles after processing_done.
  - Required: dp_vec_index=0, dot_product_result=42, exactly one result_valid and one processing_done, done pulse, rows_written=1.
- Three rows with wrap:
  - Stimulus: num_results=3, base_addr=14, core results 10, 15, 20.
  - Required: dp_vec_index sequence 14, 15, 0; results presented in order 10, 15, 20; done after the third writer_done; rows_written=3.
- Zero-length job:
  - Stimulus: num_results=0.
  - Required: done pulses within 2 cycles of start, no dp_start or result_valid, busy stays 0.
- Mid-job abort:
  - Stimulus: num_results=4, abort while in WAIT_DONE of row 2.
  - Required: FSM in IDLE next cycle, busy=0, no done pulse, rows_written=1; a following start with num_results=1 completes normally.
- Protocol robustness:
  - Stimulus: start asserted while busy; a spurious dp_valid during WAIT_BUSY.
  - Required: both ignored; a 300 (0x12C) result passes through unmodified as 18 bits.
- Timeout (SEQ_TIMEOUT_EN, TIMEOUT_CYCLES=64):
  - Stimulus: writer_busy never asserted.
  - Required: error=1 exactly 64 cycles after WAIT_BUSY entry, busy=0, no done pulse; error clears on the next start.

Source files
------------

// File: rtl/dot_product_sequencer_if.sv
// Handshake bundle shared by the job sequencer, host control registers,
// dot-product core and output memory writer.
interface dot_product_sequencer_if #(
  parameter int ADDR_WIDTH   = 4,
  parameter int RESULT_WIDTH = 18
);
  logic                    start;
  logic [ADDR_WIDTH:0]     num_results;
  logic [ADDR_WIDTH-1:0]   base_addr;
  logic                    abort;
  logic                    dp_start;
  logic [ADDR_WIDTH-1:0]   dp_vec_index;
  logic [RESULT_WIDTH-1:0] dp_result;
  logic                    dp_valid;
  logic [RESULT_WIDTH-1:0] dot_product_result;
  logic                    result_valid;
  logic                    processing_done;
  logic                    writer_busy;
  logic                    writer_done;
  logic                    busy;
  logic                    done;
  logic [ADDR_WIDTH:0]     rows_written;
  logic                    error;

  // Sequencer side
  modport master (
    input  start, num_results, base_addr, abort,
    input  dp_result, dp_valid, writer_busy, writer_done,
    output dp_start, dp_vec_index, dot_product_result, result_valid,
    output processing_done, busy, done, rows_written, error
  );

  // Host / core / writer side
  modport slave (
    output start, num_results, base_addr, abort,
    output dp_result, dp_valid, writer_busy, writer_done,
    input  dp_start, dp_vec_index, dot_product_result, result_valid,
    input  processing_done, busy, done, rows_written, error
  );
endinterface

// File: rtl/dot_product_sequencer.sv
// Job-level controller: issues one dot product per row and hands each result to the writer.
// Optional watchdog on the wait states is enabled by defining SEQ_TIMEOUT_EN.
module dot_product_sequencer #(
  parameter int DATA_WIDTH     = 8,
  parameter int VECTOR_WIDTH   = 4,
  parameter int ADDR_WIDTH     = 4,
  parameter int RESULT_WIDTH   = 2*DATA_WIDTH + $clog2(VECTOR_WIDTH),
  parameter int TIMEOUT_CYCLES = 64
) (
  input logic                     clk,
  input logic                     rst_n,
  dot_product_sequencer_if.master seq
);

  localparam int CW = ADDR_WIDTH + 1;

  typedef enum logic [3:0] {
    IDLE, ISSUE, WAIT_DP, PUSH, WAIT_BUSY, COMMIT, WAIT_DONE, NEXT, FINISH
  } state_t;

  state_t                  state_reg, state_next;
  logic [CW-1:0]           num_results_reg, num_results_next;
  logic [CW-1:0]           rows_written_reg, rows_written_next;
  logic [ADDR_WIDTH-1:0]   base_addr_reg, base_addr_next;
  logic [RESULT_WIDTH-1:0] result_reg, result_next;
  logic [CW-1:0]           rows_inc;
  logic                    timeout;

  assign rows_inc = rows_written_reg + CW'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg        <= IDLE;
      num_results_reg  <= '0;
      rows_written_reg <= '0;
      base_addr_reg    <= '0;
      result_reg       <= '0;
    end else begin
      state_reg        <= state_next;
      num_results_reg  <= num_results_next;
      rows_written_reg <= rows_written_next;
      base_addr_reg    <= base_addr_next;
      result_reg       <= result_next;
    end
  end

  always_comb begin
    state_next        = state_reg;
    num_results_next  = num_results_reg;
    rows_written_next = rows_written_reg;
    base_addr_next    = base_addr_reg;
    result_next       = result_reg;
    // abort outranks every other transition, including the NEXT increment
    if (state_reg != IDLE && seq.abort) begin
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE: begin
          if (seq.start) begin
            num_results_next  = seq.num_results;
            base_addr_next    = seq.base_addr;
            rows_written_next = '0;
            state_next        = (seq.num_results == '0) ? FINISH : ISSUE;
          end
        end
        ISSUE:   state_next = WAIT_DP;
        WAIT_DP: begin
          if (seq.dp_valid) begin
            result_next = seq.dp_result;
            state_next  = PUSH;
          end else if (timeout) begin
            state_next = IDLE;
          end
        end
        PUSH:      state_next = WAIT_BUSY;
        WAIT_BUSY: begin
          if (seq.writer_busy)  state_next = COMMIT;
          else if (timeout)     state_next = IDLE;
        end
        COMMIT:    state_next = WAIT_DONE;
        WAIT_DONE: begin
          if (seq.writer_done)  state_next = NEXT;
          else if (timeout)     state_next = IDLE;
        end
        NEXT: begin
          rows_written_next = rows_inc;
          state_next        = (rows_inc == num_results_reg) ? FINISH : ISSUE;
        end
        FINISH:  state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

`ifdef SEQ_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TO_W-1:0] to_cnt_reg, to_cnt_next;
  logic            error_reg, error_next;
  logic            in_wait, awaited;

  always_comb begin
    in_wait = 1'b0;
    awaited = 1'b0;
    case (state_reg)
      WAIT_DP:   begin in_wait = 1'b1; awaited = seq.dp_valid;    end
      WAIT_BUSY: begin in_wait = 1'b1; awaited = seq.writer_busy; end
      WAIT_DONE: begin in_wait = 1'b1; awaited = seq.writer_done; end
      default:   begin in_wait = 1'b0; awaited = 1'b0;            end
    endcase
  end

  // Counter restarts on every state change, so each wait gets a fresh budget
  assign timeout     = in_wait && !awaited && (to_cnt_reg == TO_W'(TIMEOUT_CYCLES - 1));
  assign to_cnt_next = (!in_wait || state_next != state_reg) ? '0 : to_cnt_reg + TO_W'(1);

  always_comb begin
    error_next = error_reg;
    if (state_reg == IDLE && seq.start)
      error_next = 1'b0;
    else if (timeout && !seq.abort)
      error_next = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt_reg <= '0;
      error_reg  <= 1'b0;
    end else begin
      to_cnt_reg <= to_cnt_next;
      error_reg  <= error_next;
    end
  end

  assign seq.error = error_reg;
`else
  assign timeout   = 1'b0;
  assign seq.error = 1'b0;
`endif

  assign seq.dp_start           = (state_reg == ISSUE);
  assign seq.result_valid       = (state_reg == PUSH);
  assign seq.processing_done    = (state_reg == COMMIT);
  assign seq.done               = (state_reg == FINISH);
  assign seq.busy               = (state_reg != IDLE) && (state_reg != FINISH);
  assign seq.dot_product_result = result_reg;
  assign seq.rows_written       = rows_written_reg;
  assign seq.dp_vec_index       = base_addr_reg + rows_written_reg[ADDR_WIDTH-1:0];

endmodule

// File: tb/tb_dot_product_sequencer.sv
// Directed bench for dot_product_sequencer with simple core and writer responders.
module tb_dot_product_sequencer;

  logic clk;
  logic rst_n;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_err = 0;

  dot_product_sequencer_if #(.ADDR_WIDTH(4), .RESULT_WIDTH(18)) seq_if ();

  dot_product_sequencer #(
    .DATA_WIDTH(8), .VECTOR_WIDTH(4), .ADDR_WIDTH(4), .TIMEOUT_CYCLES(64)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .seq   (seq_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // responder knobs
  int   dp_delay = 3;
  int   wr_done_delay = 2;
  bit   wr_en = 1'b1;
  bit   spur_en = 1'b0;
  logic [17:0] core_q[$];

  // monitor records
  int          vec_q[$];
  int          issue_cyc_q[$];
  logic [17:0] rv_q[$];
  logic [17:0] pd_q[$];
  int          done_cnt = 0;
  bit          busy_seen = 1'b0;
  int          start_cyc = 0;
  int          last_latency = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end else begin
      $display("ok   %s got=%0d", tag, got);
    end
  endtask

  task automatic clear_mon();
    vec_q.delete();
    issue_cyc_q.delete();
    rv_q.delete();
    pd_q.delete();
    done_cnt  = 0;
    busy_seen = 1'b0;
  endtask

  // which: 0 done, 1 processing_done, 2 result_valid, 3 error
  task automatic wait_for(input int which, input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      case (which)
        0:       ok = seq_if.done;
        1:       ok = seq_if.processing_done;
        2:       ok = seq_if.result_valid;
        default: ok = seq_if.error;
      endcase
      if (ok) break;
      @(negedge clk);
    end
  endtask

  task automatic run_job(input string tag, input logic [4:0] n, input logic [3:0] b);
    bit ok;
    @(negedge clk);
    seq_if.start       = 1'b1;
    seq_if.num_results = n;
    seq_if.base_addr   = b;
    start_cyc          = cyc;
    @(negedge clk);
    seq_if.start = 1'b0;
    wait_for(0, 400, ok);
    last_latency = cyc - start_cyc;
    check({tag, "_done_seen"}, ok, 1);
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (seq_if.dp_start) begin
      vec_q.push_back(int'(seq_if.dp_vec_index));
      issue_cyc_q.push_back(cyc);
    end
    if (seq_if.result_valid)    rv_q.push_back(seq_if.dot_product_result);
    if (seq_if.processing_done) pd_q.push_back(seq_if.dot_product_result);
    if (seq_if.done)            done_cnt++;
    if (seq_if.busy)            busy_seen = 1'b1;
  end

  // dot-product core: answers each dp_start after dp_delay cycles
  initial begin
    forever begin
      @(negedge clk);
      if (seq_if.dp_start) begin
        repeat (dp_delay) @(negedge clk);
        seq_if.dp_result = (core_q.size() > 0) ? core_q.pop_front() : 18'h0;
        seq_if.dp_valid  = 1'b1;
        @(negedge clk);
        seq_if.dp_valid = 1'b0;
        if (spur_en) begin
          @(negedge clk);
          seq_if.dp_result = 18'h3FFFF;
          seq_if.dp_valid  = 1'b1;
          @(negedge clk);
          seq_if.dp_valid = 1'b0;
        end
      end
    end
  end

  // output writer: busy right after result_valid, done wr_done_delay cycles after commit
  initial begin
    forever begin
      @(negedge clk);
      if (seq_if.result_valid && wr_en) begin
        seq_if.writer_busy = 1'b1;
        for (int i = 0; i < 200; i++) begin
          @(negedge clk);
          if (seq_if.processing_done) break;
        end
        seq_if.writer_busy = 1'b0;
        repeat (wr_done_delay) @(negedge clk);
        seq_if.writer_done = 1'b1;
        @(negedge clk);
        seq_if.writer_done = 1'b0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout got=%0d exp=0", cyc);
    $fatal(1, "bench time limit");
  end

  initial begin
    bit ok;
    int p;
    rst_n              = 1'b0;
    seq_if.start       = 1'b0;
    seq_if.num_results = '0;
    seq_if.base_addr   = '0;
    seq_if.abort       = 1'b0;
    seq_if.dp_result   = '0;
    seq_if.dp_valid    = 1'b0;
    seq_if.writer_busy = 1'b0;
    seq_if.writer_done = 1'b0;

    // reset state
    repeat (3) @(negedge clk);
    check("rst_dp_start", seq_if.dp_start, 0);
    check("rst_result_valid", seq_if.result_valid, 0);
    check("rst_processing_done", seq_if.processing_done, 0);
    check("rst_busy", seq_if.busy, 0);
    check("rst_done", seq_if.done, 0);
    check("rst_rows_written", seq_if.rows_written, 0);
    check("rst_result", seq_if.dot_product_result, 0);
    check("rst_vec_index", seq_if.dp_vec_index, 0);
    check("rst_error", seq_if.error, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // single row
    clear_mon();
    core_q = '{18'd42};
    dp_delay = 3; wr_done_delay = 2;
    run_job("single", 5'd1, 4'd0);
    check("single_issues", vec_q.size(), 1);
    check("single_vec_index", vec_q[0], 0);
    check("single_rv_count", rv_q.size(), 1);
    check("single_pd_count", pd_q.size(), 1);
    check("single_result", rv_q[0], 42);
    check("single_done_count", done_cnt, 1);
    check("single_rows_written", seq_if.rows_written, 1);
    check("single_busy_after", seq_if.busy, 0);

    // three rows wrapping past the top of the address space, minimum-latency responders
    clear_mon();
    core_q = '{18'd10, 18'd15, 18'd20};
    dp_delay = 1; wr_done_delay = 1;
    run_job("wrap", 5'd3, 4'd14);
    check("wrap_issues", vec_q.size(), 3);
    check("wrap_vec0", vec_q[0], 14);
    check("wrap_vec1", vec_q[1], 15);
    check("wrap_vec2", vec_q[2], 0);
    check("wrap_res0", rv_q[0], 10);
    check("wrap_res1", rv_q[1], 15);
    check("wrap_res2", rv_q[2], 20);
    check("wrap_row_latency", issue_cyc_q[1] - issue_cyc_q[0], 7);
    check("wrap_done_count", done_cnt, 1);
    check("wrap_rows_written", seq_if.rows_written, 3);

    // zero-length job
    clear_mon();
    run_job("zero", 5'd0, 4'd7);
    check("zero_done_latency_le2", (last_latency <= 2) ? 1 : 0, 1);
    check("zero_issues", vec_q.size(), 0);
    check("zero_rv_count", rv_q.size(), 0);
    check("zero_busy_seen", busy_seen, 0);
    check("zero_rows_written", seq_if.rows_written, 0);

    // abort in WAIT_DONE of the second row
    clear_mon();
    core_q = '{18'd1, 18'd2, 18'd3, 18'd4};
    dp_delay = 2; wr_done_delay = 6;
    @(negedge clk);
    seq_if.start = 1'b1; seq_if.num_results = 5'd4; seq_if.base_addr = 4'd0;
    @(negedge clk);
    seq_if.start = 1'b0;
    wait_for(1, 200, ok);
    check("abort_first_commit_seen", ok, 1);
    @(negedge clk);
    wait_for(1, 200, ok);
    check("abort_second_commit_seen", ok, 1);
    @(negedge clk);
    seq_if.abort = 1'b1;
    @(negedge clk);
    seq_if.abort = 1'b0;
    check("abort_busy", seq_if.busy, 0);
    check("abort_strobes", {seq_if.dp_start, seq_if.result_valid, seq_if.processing_done}, 0);
    check("abort_rows_written", seq_if.rows_written, 1);
    repeat (10) @(negedge clk);
    check("abort_no_done", done_cnt, 0);
    check("abort_stays_idle", seq_if.busy, 0);
    core_q.delete();
    clear_mon();
    core_q = '{18'd99};
    dp_delay = 1; wr_done_delay = 1;
    run_job("after_abort", 5'd1, 4'd5);
    check("after_abort_vec", vec_q[0], 5);
    check("after_abort_result", rv_q[0], 99);
    check("after_abort_rows", seq_if.rows_written, 1);

    // start while busy and a spurious dp_valid in WAIT_BUSY are ignored
    clear_mon();
    core_q = '{18'h0012C};
    dp_delay = 3; wr_done_delay = 2; spur_en = 1'b1;
    @(negedge clk);
    seq_if.start = 1'b1; seq_if.num_results = 5'd1; seq_if.base_addr = 4'd3;
    @(negedge clk);
    seq_if.num_results = 5'd5; seq_if.base_addr = 4'd9;
    repeat (2) @(negedge clk);
    seq_if.start = 1'b0; seq_if.num_results = '0; seq_if.base_addr = '0;
    wait_for(0, 200, ok);
    check("robust_done_seen", ok, 1);
    @(negedge clk);
    spur_en = 1'b0;
    check("robust_issues", vec_q.size(), 1);
    check("robust_vec", vec_q[0], 3);
    check("robust_push_result", rv_q[0], 32'h12C);
    check("robust_commit_result", pd_q[0], 32'h12C);
    check("robust_result_hold", seq_if.dot_product_result, 32'h12C);
    check("robust_rows_written", seq_if.rows_written, 1);
    check("robust_done_count", done_cnt, 1);
    repeat (5) @(negedge clk);

    // asynchronous reset mid-job
    clear_mon();
    core_q = '{18'd7, 18'd8};
    dp_delay = 6;
    @(negedge clk);
    seq_if.start = 1'b1; seq_if.num_results = 5'd2; seq_if.base_addr = 4'd0;
    @(negedge clk);
    seq_if.start = 1'b0;
    repeat (2) @(negedge clk);
    check("midrst_busy_before", seq_if.busy, 1);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_busy", seq_if.busy, 0);
    check("midrst_rows", seq_if.rows_written, 0);
    repeat (10) @(negedge clk);
    rst_n = 1'b1;
    check("midrst_no_done", done_cnt, 0);
    core_q.delete();
    dp_delay = 1;
    repeat (2) @(negedge clk);

`ifdef SEQ_TIMEOUT_EN
    // writer never accepts: watchdog fires 64 cycles into WAIT_BUSY
    clear_mon();
    wr_en = 1'b0;
    core_q = '{18'd5};
    @(negedge clk);
    seq_if.start = 1'b1; seq_if.num_results = 5'd1; seq_if.base_addr = 4'd0;
    @(negedge clk);
    seq_if.start = 1'b0;
    wait_for(2, 100, ok);
    check("to_push_seen", ok, 1);
    p = cyc;
    @(negedge clk);
    wait_for(3, 200, ok);
    check("to_error_seen", ok, 1);
    check("to_error_delay", cyc - p, 65);
    check("to_busy", seq_if.busy, 0);
    @(negedge clk);
    check("to_no_done", done_cnt, 0);
    wr_en = 1'b1;
    run_job("to_clear", 5'd0, 4'd0);
    check("to_error_cleared", seq_if.error, 0);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
